cdf_accumulate: RTL
===================

# cdf_accumulate

Parametrised running-sum stage of the CDF pipeline: it converts a stream of histogram bin counts into cumulative counts, one output per input bin. Each output carries the bin's store address. The block adds frame delimiting, valid/ready backpressure, configurable widths, overflow detection and capture of the minimum non-zero CDF value. It sits between the histogram read-out and the CDF store/normalise stage.

## Interface
- DATA_W, 16, width of an incoming bin count
- ACC_W, 24, accumulator and result width; must satisfy ACC_W >= DATA_W
- ADDR_W, 16, store address width
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_first  in  1  beat is the first bin of a frame
- in_last  in  1  beat is the last bin of a frame
- in_data  in  DATA_W  bin count, unsigned
- in_addr  in  ADDR_W  store address for this bin
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts the result
- out_acc  out  ACC_W  cumulative count up to and including this bin
- out_addr  out  ADDR_W  in_addr delayed alongside its result
- out_last  out  1  result belongs to the last bin of the frame
- done  out  1  one-cycle pulse marking frame completion
- cdf_min  out  ACC_W  first non-zero out_acc of the current or last frame
- cdf_min_valid  out  1  cdf_min holds a value for this frame
- overflow  out  1  sticky; the sum exceeded 2^ACC_W-1 in this frame
- frame_err  out  1  sticky; in_first was seen mid-frame

## Operation
- in_ready = !out_valid || out_ready (combinational). A beat is accepted when in_valid && in_ready.
- FSM states:
  - IDLE: no frame open.
  - ACCUM: frame open.
  - Reset enters IDLE.
- Frame start: an accepted beat in IDLE, or an accepted beat with in_first in either state.
  - The sum restarts at the zero-extended in_data.
  - cdf_min_valid, overflow and frame_err clear.
  - State goes to ACCUM, unless in_last is also set; then the frame is single-beat and the state stays IDLE.
- Accepted beat in ACCUM without in_first: sum = acc + zext(in_data).
- in_first in ACCUM: counts as a frame start as above, and frame_err then sets to 1.
- in_last on an accepted beat: state returns to IDLE.
- Arithmetic uses ACC_W+1 bits. A carry out of bit ACC_W-1 sets overflow. The stored result follows the Configuration rule.
- cdf_min capture: on the first accepted beat of a frame whose result is non-zero, cdf_min loads that result and cdf_min_valid sets. Both hold until the next frame start; cdf_min itself is not cleared.
- When out_valid && !out_ready, the output registers and the accumulator hold. No beat is accepted and no data is lost.
- Reset values: out_valid, out_acc, out_addr, out_last, done, cdf_min, cdf_min_valid, overflow and frame_err are all 0. Because out_valid is 0, in_ready is 1.
- Reset mid-frame abandons the frame. The next accepted beat is a frame start whether or not in_first is set.

## Timing
- Latency: a beat accepted in cycle N gives out_valid in cycle N+1, with out_acc, out_addr and out_last registered together.
- Throughput: one beat per cycle while out_ready = 1.
- done rises in the same cycle as out_valid for the out_last beat and lasts one cycle. It does not wait for out_ready.
- overflow, frame_err and cdf_min/cdf_min_valid update in the same cycle as the out_valid of the beat that caused them.
- With in_valid low or the block stalled, the accumulator holds across any number of gap cycles.

## Configuration
- CDF_ACC_SAT_EN defined: on carry out, the result clamps to 2^ACC_W-1 and later additions stay clamped until the next frame start. overflow is still set.
- CDF_ACC_SAT_EN undefined: the result wraps modulo 2^ACC_W. overflow is still set.

## Test plan
- Frame of addresses 0..3, data 0,5,0,7, out_ready=1 -> out_acc 0,5,5,12 and out_addr 0..3. out_last and done fire on the 4th output. cdf_min=5, cdf_min_valid=1.
- Same frame with out_ready low for 3 cycles after the 2nd output -> out_valid holds with out_acc=5 and in_ready=0. The sequence then resumes 5,12 with no loss or duplication.
- ACC_W=16, DATA_W=16, data 0xFFFF then 0x0002:
  - Without the macro -> out_acc 0xFFFF then 0x0001, overflow=1.
  - With CDF_ACC_SAT_EN -> out_acc 0xFFFF then 0xFFFF, overflow=1.
- Single beat with in_first and in_last set, data 9 -> out_acc=9, done pulse, state stays IDLE. The next frame restarts from 0.
- in_first asserted on the 3rd beat of a frame, data 4,4,6 -> out_acc 4,8,6 and frame_err=1. cdf_min=6, since capture restarts with the new frame.
- reset_n pulsed low after 2 beats (acc=8), then a beat with data 3 and no in_first -> all outputs read 0 during reset, and the first output after reset is out_acc=3.

Source files
------------

// File: rtl/cdf_accumulate.sv
// -----------------------------------------------------------------------------
// cdf_accumulate
//   Running-sum stage of the CDF pipeline. Turns a stream of histogram bin
//   counts into cumulative counts, one result per bin, each tagged with its
//   store address. The block handles frame delimiting, valid/ready
//   backpressure, overflow detection and capture of the minimum non-zero CDF
//   value (the first non-zero cumulative result of the frame).
//
//   Optional feature macro: CDF_ACC_SAT_EN
//     defined   : on carry out the result clamps to 2^ACC_W-1 and stays there
//                 until the next frame start
//     undefined : the result wraps modulo 2^ACC_W
//     overflow is flagged in both builds.
//
// Parameters
//   DATA_W  incoming bin count width
//   ACC_W   accumulator / result width (must be >= DATA_W)
//   ADDR_W  store address width
//
// Ports
//   clock, reset_n            rising-edge clock, async active-low reset
//   in_valid/in_ready         input handshake
//   in_first/in_last          frame delimiters of the input beat
//   in_data, in_addr          bin count and its store address
//   out_valid/out_ready       output handshake
//   out_acc, out_addr         cumulative count and address of the beat
//   out_last                  result belongs to the last bin of the frame
//   done                      one-cycle pulse with the out_last result
//   cdf_min, cdf_min_valid    first non-zero result of the frame
//   overflow                  sticky per frame: sum exceeded 2^ACC_W-1
//   frame_err                 sticky per frame: in_first seen mid-frame
// -----------------------------------------------------------------------------
module cdf_accumulate #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 24,
   parameter int ADDR_W = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_first,
   input  logic              in_last,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              done,
   output logic [ACC_W-1:0]  cdf_min,
   output logic              cdf_min_valid,
   output logic              overflow,
   output logic              frame_err
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ACCUM = 1'b1;

   logic [0:0]       state;
   logic             accept;
   logic             frame_start;
   logic [ACC_W-1:0] acc_base;
   logic [ACC_W:0]   sum;
   logic             carry;
   logic [ACC_W-1:0] result;
   logic             result_nz;

   // The output register doubles as the accumulator: it only changes on an
   // accepted beat, and a beat can only be accepted once the previous result
   // has left (or is leaving), so its value is always the running sum.
   assign in_ready    = !out_valid || out_ready;
   assign accept      = in_valid && in_ready;
   assign frame_start = accept && ((state == IDLE) || in_first);

   assign acc_base = frame_start ? '0 : out_acc;
   assign sum      = {1'b0, acc_base} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
   assign carry    = sum[ACC_W];

`ifdef CDF_ACC_SAT_EN
   // A clamped accumulator sits at all-ones, so any later non-zero addend
   // carries again and re-clamps; adding zero keeps all-ones unchanged.
   assign result = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
   assign result = sum[ACC_W-1:0];
`endif

   assign result_nz = |result;

   // Frame state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else if (accept) begin
         state <= in_last ? IDLE : ACCUM;
      end
   end

   // Result registers; they hold while stalled
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_addr  <= '0;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_acc   <= result;
         out_addr  <= in_addr;
         out_last  <= in_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // done marks the arrival of the last result, independent of out_ready
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         done <= 1'b0;
      end else begin
         done <= accept && in_last;
      end
   end

   // Per-frame status: a frame start restarts all sticky flags from the
   // current beat's own contribution.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else if (frame_start) begin
         overflow  <= carry;
         frame_err <= (state == ACCUM) && in_first;
      end else if (accept && carry) begin
         overflow  <= 1'b1;
      end
   end

   // Minimum non-zero CDF: the running sum is monotonic (or clamps), so the
   // first non-zero result is the minimum. cdf_min keeps its old value
   // across a frame start; only the valid flag is cleared.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cdf_min       <= '0;
         cdf_min_valid <= 1'b0;
      end else if (frame_start) begin
         cdf_min_valid <= result_nz;
         if (result_nz) cdf_min <= result;
      end else if (accept && !cdf_min_valid && result_nz) begin
         cdf_min_valid <= 1'b1;
         cdf_min       <= result;
      end
   end

endmodule
